// File: rtl/vscale_htif_pcr_arb_pkg.sv
// Shared encodings and defaults for the HTIF PCR arbiter slice.
// Widths mirror the core's CSR_ADDR_WIDTH / HTIF_PCR_WIDTH control constants.
package vscale_htif_pcr_arb_pkg;

  typedef enum logic [1:0] {
    HTIF_ARB_IDLE    = 2'd0,
    HTIF_ARB_REQ     = 2'd1,
    HTIF_ARB_RESP    = 2'd2,
    HTIF_ARB_DELIVER = 2'd3
  } htif_arb_state_e;

  localparam int HTIF_PCR_WIDTH_DEF = 64;
  localparam int CSR_ADDR_WIDTH_DEF = 12;

  // Data returned to a requester whose downstream response never arrived.
  localparam logic [HTIF_PCR_WIDTH_DEF-1:0] HTIF_ARB_TIMEOUT_DATA = '1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vscale_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Returns a one-hot grant plus its encoded index; grant_any flags a winner.
module vscale_rr_arbiter
  import vscale_htif_pcr_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IW = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     grant_idx,
  output logic              grant_any
);

  function automatic int wrap(input int v);
    return (v >= NUM_CH) ? v - NUM_CH : v;
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Outer loop walks priority order starting at ptr; first hit locks the grant.
    for (int off = 0; off < NUM_CH; off++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!grant_any && req[i] && (i == wrap(int'(ptr) + off))) begin
          grant_any = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/vscale_htif_pcr_arb.sv
// N-channel round-robin front end for the core's single HTIF PCR port,
// with response routing, a response watchdog and a stale-response drop counter.
//
// state   | meaning
// IDLE    | pick a channel, accept its request; drain stray core responses
// REQ     | present latched request to the core until it is taken
// RESP    | wait for the core response or watchdog expiry
// DELIVER | hand response to the granted channel; drop stray core responses
module vscale_htif_pcr_arb
  import vscale_htif_pcr_arb_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CSR_ADDR_WIDTH = CSR_ADDR_WIDTH_DEF,
  parameter int HTIF_PCR_WIDTH = HTIF_PCR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW = idx_width(NUM_CH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CH-1:0]                  ch_req_valid,
  output logic [NUM_CH-1:0]                  ch_req_ready,
  input  logic [NUM_CH-1:0]                  ch_req_rw,
  input  logic [NUM_CH*CSR_ADDR_WIDTH-1:0]   ch_req_addr,
  input  logic [NUM_CH*HTIF_PCR_WIDTH-1:0]   ch_req_data,
  output logic [NUM_CH-1:0]                  ch_resp_valid,
  input  logic [NUM_CH-1:0]                  ch_resp_ready,
  output logic [HTIF_PCR_WIDTH-1:0]          ch_resp_data,
  output logic                               ch_resp_err,
  output logic                               htif_pcr_req_valid,
  input  logic                               htif_pcr_req_ready,
  output logic                               htif_pcr_req_rw,
  output logic [CSR_ADDR_WIDTH-1:0]          htif_pcr_req_addr,
  output logic [HTIF_PCR_WIDTH-1:0]          htif_pcr_req_data,
  input  logic                               htif_pcr_resp_valid,
  output logic                               htif_pcr_resp_ready,
  input  logic [HTIF_PCR_WIDTH-1:0]          htif_pcr_resp_data,
  output logic                               busy,
  output logic [IW-1:0]                      grant_id,
  output logic [7:0]                         drop_count
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  htif_arb_state_e            state_q, state_d;
  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]              grant_q, grant_d;
  logic                       rw_q, rw_d;
  logic [CSR_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [HTIF_PCR_WIDTH-1:0]  wdata_q, wdata_d;
  logic [HTIF_PCR_WIDTH-1:0]  rdata_q, rdata_d;
  logic                       err_q, err_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [7:0]                 drop_q, drop_d;

  logic [NUM_CH-1:0]          arb_grant;
  logic [IW-1:0]              arb_idx;
  logic                       arb_any;

  logic [NUM_CH-1:0]          req_ready_raw, resp_valid_raw;
  logic                       pcr_req_valid_raw, pcr_resp_ready_raw;
  logic                       sel_resp_ready;
  logic                       tmo_fire;

  vscale_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req       (ch_req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign tmo_fire = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    sel_resp_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(grant_q) == i) sel_resp_ready = ch_resp_ready[i];
    end
  end

  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    grant_d            = grant_q;
    rw_d               = rw_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    rdata_d            = rdata_q;
    err_d              = err_q;
    cnt_d              = cnt_q;
    drop_d             = drop_q;
    req_ready_raw      = '0;
    resp_valid_raw     = '0;
    pcr_req_valid_raw  = 1'b0;
    pcr_resp_ready_raw = 1'b0;

    unique case (state_q)
      HTIF_ARB_IDLE: begin
        pcr_resp_ready_raw = 1'b1;
        req_ready_raw      = arb_grant;
        if (arb_any) begin
          grant_d = arb_idx;
          state_d = HTIF_ARB_REQ;
          for (int i = 0; i < NUM_CH; i++) begin
            if (arb_grant[i]) begin
              rw_d    = ch_req_rw[i];
              addr_d  = ch_req_addr[i*CSR_ADDR_WIDTH +: CSR_ADDR_WIDTH];
              wdata_d = ch_req_data[i*HTIF_PCR_WIDTH +: HTIF_PCR_WIDTH];
            end
          end
        end
      end
      HTIF_ARB_REQ: begin
        pcr_req_valid_raw = 1'b1;
        if (htif_pcr_req_ready) begin
          cnt_d   = '0;
          state_d = HTIF_ARB_RESP;
        end
      end
      HTIF_ARB_RESP: begin
        pcr_resp_ready_raw = 1'b1;
        // A real response beats a watchdog expiry in the same cycle.
        if (htif_pcr_resp_valid) begin
          rdata_d = htif_pcr_resp_data;
          err_d   = 1'b0;
          state_d = HTIF_ARB_DELIVER;
        end else if (tmo_fire) begin
          rdata_d = {HTIF_PCR_WIDTH{HTIF_ARB_TIMEOUT_DATA[0]}};
          err_d   = 1'b1;
          state_d = HTIF_ARB_DELIVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HTIF_ARB_DELIVER: begin
        pcr_resp_ready_raw = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          resp_valid_raw[i] = (int'(grant_q) == i);
        end
        if (sel_resp_ready) begin
          rr_ptr_d = (int'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
          state_d  = HTIF_ARB_IDLE;
        end
      end
      default: state_d = HTIF_ARB_IDLE;
    endcase

    if ((state_q == HTIF_ARB_IDLE || state_q == HTIF_ARB_DELIVER) &&
        htif_pcr_resp_valid && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HTIF_ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // Handshake outputs are forced low while reset is held, not just after the next edge.
  assign ch_req_ready        = req_ready_raw  & {NUM_CH{reset}};
  assign ch_resp_valid       = resp_valid_raw & {NUM_CH{reset}};
  assign htif_pcr_req_valid  = pcr_req_valid_raw  & reset;
  assign htif_pcr_resp_ready = pcr_resp_ready_raw & reset;

  assign htif_pcr_req_rw   = rw_q;
  assign htif_pcr_req_addr = addr_q;
  assign htif_pcr_req_data = wdata_q;
  assign ch_resp_data      = rdata_q;
  assign ch_resp_err       = err_q;
  assign busy              = (state_q != HTIF_ARB_IDLE);
  assign grant_id          = grant_q;
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_vscale_htif_pcr_arb.sv
// Directed bench for vscale_htif_pcr_arb (2 channels, 8-cycle watchdog).
// Inputs change and outputs are sampled on the falling edge.
module tb_vscale_htif_pcr_arb;
  localparam int NC  = 2;
  localparam int AW  = 12;
  localparam int DW  = 64;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    ch_req_valid, ch_req_ready, ch_req_rw;
  logic [NC*AW-1:0] ch_req_addr;
  logic [NC*DW-1:0] ch_req_data;
  logic [NC-1:0]    ch_resp_valid, ch_resp_ready;
  logic [DW-1:0]    ch_resp_data;
  logic             ch_resp_err;
  logic             htif_pcr_req_valid, htif_pcr_req_ready, htif_pcr_req_rw;
  logic [AW-1:0]    htif_pcr_req_addr;
  logic [DW-1:0]    htif_pcr_req_data;
  logic             htif_pcr_resp_valid, htif_pcr_resp_ready;
  logic [DW-1:0]    htif_pcr_resp_data;
  logic             busy;
  logic [0:0]       grant_id;
  logic [7:0]       drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  int waited;

  always #5 clk = ~clk;

  vscale_htif_pcr_arb #(
    .NUM_CH(NC), .CSR_ADDR_WIDTH(AW), .HTIF_PCR_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_rw(ch_req_rw),
    .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data),
    .ch_resp_valid(ch_resp_valid), .ch_resp_ready(ch_resp_ready),
    .ch_resp_data(ch_resp_data), .ch_resp_err(ch_resp_err),
    .htif_pcr_req_valid(htif_pcr_req_valid), .htif_pcr_req_ready(htif_pcr_req_ready),
    .htif_pcr_req_rw(htif_pcr_req_rw), .htif_pcr_req_addr(htif_pcr_req_addr),
    .htif_pcr_req_data(htif_pcr_req_data),
    .htif_pcr_resp_valid(htif_pcr_resp_valid), .htif_pcr_resp_ready(htif_pcr_resp_ready),
    .htif_pcr_resp_data(htif_pcr_resp_data),
    .busy(busy), .grant_id(grant_id), .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset               = 1'b0;
    ch_req_valid        = 2'b11;
    ch_req_rw           = '0;
    ch_req_addr         = '0;
    ch_req_data         = '0;
    ch_resp_ready       = '0;
    htif_pcr_req_ready  = 1'b0;
    htif_pcr_resp_valid = 1'b0;
    htif_pcr_resp_data  = '0;

    // Reset state, with requests pending to prove ready is held low
    #2;
    check("rst_busy",       busy, 0);
    check("rst_req_ready",  ch_req_ready, 0);
    check("rst_pcr_valid",  htif_pcr_req_valid, 0);
    check("rst_pcr_rready", htif_pcr_resp_ready, 0);
    check("rst_resp_valid", ch_resp_valid, 0);
    check("rst_err",        ch_resp_err, 0);
    check("rst_data",       ch_resp_data, 0);
    check("rst_addr",       htif_pcr_req_addr, 0);
    check("rst_drop",       drop_count, 0);
    check("rst_grant",      grant_id, 0);
    nxt(); nxt();
    reset = 1'b1;

    // Fairness: both channels always valid, core answers immediately
    ch_req_valid           = 2'b11;
    ch_req_rw              = 2'b10;
    ch_req_addr[0*AW +: AW] = 12'h100;
    ch_req_addr[1*AW +: AW] = 12'h200;
    htif_pcr_req_ready     = 1'b1;
    ch_resp_ready          = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fair_grant", ch_req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      nxt();
      check("fair_addr",     htif_pcr_req_addr, (k % 2 == 1) ? 12'h200 : 12'h100);
      check("fair_rw",       htif_pcr_req_rw, k % 2);
      check("fair_busy_rdy", ch_req_ready, 0);
      nxt();
      htif_pcr_resp_valid = 1'b1;
      htif_pcr_resp_data  = 64'hA0 + 64'(k);
      nxt();
      htif_pcr_resp_valid = 1'b0;
      check("fair_resp_valid", ch_resp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
      check("fair_resp_data",  ch_resp_data, 64'hA0 + 64'(k));
      nxt();
    end

    // Single read on ch0, core answers three cycles after req_valid
    ch_req_valid            = 2'b01;
    ch_req_rw               = 2'b00;
    ch_req_addr[0*AW +: AW] = 12'h780;
    htif_pcr_req_ready      = 1'b0;
    ch_resp_ready           = 2'b00;
    #1;
    check("rd_accept", ch_req_ready, 2'b01);
    check("rd_idle_rready", htif_pcr_resp_ready, 1);
    nxt();
    check("rd_req_valid", htif_pcr_req_valid, 1);
    check("rd_req_addr",  htif_pcr_req_addr, 12'h780);
    check("rd_req_rw",    htif_pcr_req_rw, 0);
    check("rd_req_rready", htif_pcr_resp_ready, 0);
    check("rd_grant",     grant_id, 0);
    ch_req_valid       = 2'b00;
    htif_pcr_req_ready = 1'b1;
    nxt();
    htif_pcr_req_ready = 1'b0;
    check("rd_resp_rready", htif_pcr_resp_ready, 1);
    check("rd_req_dropped", htif_pcr_req_valid, 0);
    nxt(); nxt();
    htif_pcr_resp_valid = 1'b1;
    htif_pcr_resp_data  = 64'h1234;
    check("rd_latency", ch_resp_valid, 0);
    nxt();
    htif_pcr_resp_valid = 1'b0;
    check("rd_resp_valid", ch_resp_valid, 2'b01);
    check("rd_resp_data",  ch_resp_data, 64'h1234);
    check("rd_resp_err",   ch_resp_err, 0);
    ch_resp_ready = 2'b01;
    nxt();
    ch_resp_ready = 2'b00;
    check("rd_done_busy", busy, 0);

    // Backpressure: write on ch0 held for 5 cycles, ch1 waits
    ch_req_valid            = 2'b01;
    ch_req_rw               = 2'b01;
    ch_req_addr[0*AW +: AW] = 12'h7C0;
    ch_req_data[0*DW +: DW] = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("bp_accept", ch_req_ready, 2'b01);
    nxt();
    ch_req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid",  htif_pcr_req_valid, 1);
      check("bp_addr",   htif_pcr_req_addr, 12'h7C0);
      check("bp_data",   htif_pcr_req_data, 64'hDEAD_BEEF_0000_0001);
      check("bp_rw",     htif_pcr_req_rw, 1);
      check("bp_no_rdy", ch_req_ready, 0);
      nxt();
    end
    htif_pcr_req_ready = 1'b1;
    nxt();
    htif_pcr_req_ready      = 1'b0;
    ch_req_valid            = 2'b10;
    ch_req_rw               = 2'b00;
    ch_req_addr[1*AW +: AW] = 12'h300;
    htif_pcr_resp_valid     = 1'b1;
    htif_pcr_resp_data      = 64'h55;
    nxt();
    htif_pcr_resp_valid = 1'b0;
    check("bp_resp_valid", ch_resp_valid, 2'b01);
    check("bp_resp_data",  ch_resp_data, 64'h55);
    ch_resp_ready = 2'b01;
    nxt();
    ch_resp_ready = 2'b00;
    #1;
    check("tmo_accept", ch_req_ready, 2'b10);

    // Timeout on ch1: core never answers
    nxt();
    ch_req_valid       = 2'b00;
    htif_pcr_req_ready = 1'b1;
    check("tmo_req_addr", htif_pcr_req_addr, 12'h300);
    check("tmo_grant",    grant_id, 1);
    waited = 0;
    for (int t = 0; t < 40; t++) begin
      nxt();
      htif_pcr_req_ready = 1'b0;
      if (ch_resp_valid != 0) break;
      waited++;
    end
    check("tmo_wait",       waited, TMO);
    check("tmo_resp_valid", ch_resp_valid, 2'b10);
    check("tmo_data",       ch_resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("tmo_err",        ch_resp_err, 1);
    ch_resp_ready = 2'b10;
    nxt();
    ch_resp_ready       = 2'b00;
    htif_pcr_resp_valid = 1'b1;
    htif_pcr_resp_data  = 64'hBAD;
    #1;
    check("stale_rready", htif_pcr_resp_ready, 1);
    nxt();
    htif_pcr_resp_valid = 1'b0;
    check("stale_drop",  drop_count, 1);
    check("stale_busy",  busy, 0);
    check("stale_noresp", ch_resp_valid, 0);

    // Collision: response lands in the cycle the watchdog would fire
    ch_req_valid            = 2'b01;
    ch_req_addr[0*AW +: AW] = 12'h010;
    nxt();
    ch_req_valid       = 2'b00;
    htif_pcr_req_ready = 1'b1;
    nxt();
    htif_pcr_req_ready = 1'b0;
    repeat (TMO - 1) nxt();
    htif_pcr_resp_valid = 1'b1;
    htif_pcr_resp_data  = 64'hC0FFEE;
    nxt();
    htif_pcr_resp_valid = 1'b0;
    check("col_resp_valid", ch_resp_valid, 2'b01);
    check("col_data",       ch_resp_data, 64'hC0FFEE);
    check("col_err",        ch_resp_err, 0);
    ch_resp_ready = 2'b01;
    nxt();
    ch_resp_ready = 2'b00;
    check("col_drop", drop_count, 1);

    // Asynchronous reset while waiting in RESP for ch1
    ch_req_valid = 2'b10;
    nxt();
    ch_req_valid       = 2'b00;
    htif_pcr_req_ready = 1'b1;
    check("arst_grant_pre", grant_id, 1);
    nxt();
    htif_pcr_req_ready = 1'b0;
    check("arst_busy_pre", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy",       busy, 0);
    check("arst_pcr_valid",  htif_pcr_req_valid, 0);
    check("arst_resp_valid", ch_resp_valid, 0);
    check("arst_rready",     htif_pcr_resp_ready, 0);
    check("arst_grant",      grant_id, 0);
    nxt(); nxt();
    reset        = 1'b1;
    ch_req_valid = 2'b11;
    #1;
    check("arst_rr_from0", ch_req_ready, 2'b01);
    nxt();
    ch_req_valid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_htif_pcr_arb.md
Name: vscale_htif_pcr_arb

Overview:
Parametrised N-channel arbiter and response router for the core's single HTIF PCR port. It sits in the benchmark/test top between NUM_CH host-side requesters and vscale_top's htif_pcr_* interface.
It serialises CSR read/write requests using round-robin arbitration and returns each response to the channel that issued it. A response-timeout watchdog and a stale-response drop counter are features the single-host harness lacks.

Parameters:
NUM_CH, 2, number of host request channels (1..8)
CSR_ADDR_WIDTH, 12, PCR address width (matches `CSR_ADDR_WIDTH)
HTIF_PCR_WIDTH, 64, PCR data width (matches `HTIF_PCR_WIDTH)
TIMEOUT_CYCLES, 1024, cycles to wait for a downstream response; 0 disables the watchdog

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
ch_req_valid  in  NUM_CH  per-channel request valid
ch_req_ready  out  NUM_CH  per-channel request accept
ch_req_rw  in  NUM_CH  per-channel write (1) / read (0)
ch_req_addr  in  NUM_CH*CSR_ADDR_WIDTH  packed addresses; channel i at bits [i*W +: W]
ch_req_data  in  NUM_CH*HTIF_PCR_WIDTH  packed write data
ch_resp_valid  out  NUM_CH  one-hot response valid
ch_resp_ready  in  NUM_CH  per-channel response accept
ch_resp_data  out  HTIF_PCR_WIDTH  shared response data
ch_resp_err  out  1  response was produced by timeout
htif_pcr_req_valid  out  1  to core
htif_pcr_req_ready  in  1  from core
htif_pcr_req_rw  out  1  to core
htif_pcr_req_addr  out  CSR_ADDR_WIDTH  to core
htif_pcr_req_data  out  HTIF_PCR_WIDTH  to core
htif_pcr_resp_valid  in  1  from core
htif_pcr_resp_ready  out  1  to core
htif_pcr_resp_data  in  HTIF_PCR_WIDTH  from core
busy  out  1  state != IDLE
grant_id  out  clog2(NUM_CH) (min 1)  channel currently owning the port
drop_count  out  8  saturating count of dropped stale responses

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0, drop_count=0.
  - All valid/ready outputs 0; data/addr/err outputs 0.
- One transaction outstanding at a time. States: IDLE, REQ, RESP, DELIVER.
- IDLE:
  - Winner is the first channel with ch_req_valid set, scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
  - ch_req_ready[winner]=1 combinationally; all other ready bits are 0.
  - On accept: latch rw/addr/data and grant_id=winner, go to REQ.
  - htif_pcr_resp_ready=1 in IDLE to drain stale responses.
- REQ:
  - htif_pcr_req_valid=1 and the latched fields are driven from registers. Earliest assertion is the cycle after accept.
  - Fields stay stable until htif_pcr_req_ready. On the handshake, go to RESP and clear the counter.
  - htif_pcr_resp_ready=0 in REQ.
- RESP:
  - htif_pcr_resp_ready=1.
  - On htif_pcr_resp_valid: latch data, err=0, go to DELIVER.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES!=0: data=all ones, err=1, go to DELIVER.
  - If a response arrives in the same cycle the timeout would fire, the response wins (err=0).
- DELIVER:
  - ch_resp_valid[grant_id]=1; ch_resp_data and ch_resp_err are held from registers.
  - On ch_resp_ready[grant_id]: rr_ptr=(grant_id+1) mod NUM_CH, go to IDLE.
  - htif_pcr_resp_ready=1. Any htif_pcr_resp_valid seen here, or in IDLE, is dropped and increments drop_count (saturating at 255).
- Latency: downstream resp_valid in cycle N gives ch_resp_valid in cycle N+1. Best-case round trip is accept → req_valid +1 → resp → resp_valid +1.
- Requests on non-granted channels are never accepted while busy. Their ch_req_ready stays 0.
- Reset asserted mid-transaction abandons it. Outputs return to reset values immediately.
- NUM_CH==1: arbitration is degenerate, rr_ptr stays 0 and grant_id is constant 0.

Decomposition:
- Shared package/header (extends vscale_ctrl_constants.vh):
  - state encodings HTIF_ARB_IDLE/REQ/RESP/DELIVER (2 bits)
  - HTIF_PCR_WIDTH and CSR_ADDR_WIDTH defaults
  - the timeout data value (all ones)
- One sub-module: vscale_rr_arbiter. It takes a NUM_CH request vector and ptr, and returns a one-hot grant plus an encoded index. It is combinational and reusable.

Test Plan:
- Single read, NUM_CH=2: ch0 read addr 0x780, core returns 0x1234 three cycles after req_valid → ch_resp_valid=2'b01 next cycle with data 0x1234, err=0.
- Fairness: ch0 and ch1 both continuously valid for 4 transactions → grant order 0,1,0,1.
- Backpressure: htif_pcr_req_ready held 0 for 5 cycles → req_valid, addr and data stable for all 5 cycles; no ch_req_ready asserted to ch1 meanwhile.
- Timeout, TIMEOUT_CYCLES=8: core never responds → ch_resp_valid exactly 8 cycles after the req handshake, data=0xFFFF_FFFF_FFFF_FFFF, err=1. A later core response drops and drop_count=1.
- Collision: response arrives in the same cycle the timeout would fire → data delivered, err=0.
- Async reset in RESP, mid-cycle → busy, htif_pcr_req_valid and ch_resp_valid go 0 without a clock edge; the next request is granted starting from ch0.
